pipe_hazard_unit: RTL and testbench



---
 rtl/singlecycle_pkg.sv | 14 +
 rtl/pipe_hazard_unit_if.sv | 36 +++
 rtl/hazard_redir_arb.sv | 30 +++
 rtl/pipe_hazard_unit.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/singlecycle_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package singlecycle_pkg;

    typedef enum logic {L_IDLE, L_WAIT} lsu_state_e;

    localparam int unsigned DEF_NUM_STAGES = 5;
    localparam int unsigned DEF_NUM_REDIR  = 4;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Request/response bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_unit_if
    import singlecycle_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned NUM_REDIR  = DEF_NUM_REDIR,
    parameter int unsigned LVL_W      = $clog2(NUM_STAGES),
    parameter int unsigned SEL_W      = clog2_min1(NUM_REDIR)
);
    logic [NUM_REDIR-1:0]            i_redir_valid;
    logic [NUM_REDIR-1:0][LVL_W-1:0] i_redir_lvl;
    logic [NUM_REDIR-1:0]            o_redir_ack;
    logic [SEL_W-1:0]                o_redir_sel;
    logic                            i_load_use;
    logic                            i_lsu_valid;
    logic                            i_lsu_ready;
    logic                            o_lsu_timeout;
    logic [NUM_STAGES-1:0]           o_en;
    logic [NUM_STAGES-1:0]           o_flush;
    logic                            o_stall;
    logic [31:0]                     o_perf_stall_cnt;
    logic [31:0]                     o_perf_flush_cnt;

    modport master (
        output i_redir_valid, i_redir_lvl, i_load_use, i_lsu_valid, i_lsu_ready,
        input  o_redir_ack, o_redir_sel, o_lsu_timeout, o_en, o_flush, o_stall,
               o_perf_stall_cnt, o_perf_flush_cnt
    );

    modport slave (
        input  i_redir_valid, i_redir_lvl, i_load_use, i_lsu_valid, i_lsu_ready,
        output o_redir_ack, o_redir_sel, o_lsu_timeout, o_en, o_flush, o_stall,
               o_perf_stall_cnt, o_perf_flush_cnt
    );

endinterface

// File: rtl/hazard_redir_arb.sv
// Redirect selector: deepest flush level wins, ties resolved toward the lowest channel.
module hazard_redir_arb #(
    parameter int unsigned NUM_REDIR = 4,
    parameter int unsigned LVL_W     = 3,
    parameter int unsigned SEL_W     = 2
) (
    input  logic [NUM_REDIR-1:0]            valid,
    input  logic [NUM_REDIR-1:0][LVL_W-1:0] lvl,
    output logic                            any,
    output logic [SEL_W-1:0]                sel,
    output logic [NUM_REDIR-1:0]            onehot,
    output logic [LVL_W-1:0]                win_lvl
);

    always_comb begin
        any     = 1'b0;
        sel     = '0;
        win_lvl = '0;
        // Strict compare keeps the earlier (lower-index) channel on equal levels.
        for (int unsigned i = 0; i < NUM_REDIR; i++) begin
            if (valid[i] && (!any || (lvl[i] > win_lvl))) begin
                any     = 1'b1;
                sel     = SEL_W'(i);
                win_lvl = lvl[i];
            end
        end
        onehot = any ? (NUM_REDIR'(1) << sel) : '0;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// N-stage hazard controller: redirects, multi-cycle load-use stall, LSU wait with timeout.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_unit
    import singlecycle_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
    parameter int unsigned NUM_REDIR      = DEF_NUM_REDIR,
    parameter int unsigned MEM_REG        = 3,
    parameter int unsigned LU_REG         = 2,
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned LSU_TIMEOUT    = 0,
    parameter int unsigned LVL_W          = $clog2(NUM_STAGES)
) (
    input logic               i_clk,
    input logic               i_rst,
    pipe_hazard_unit_if.slave hz
);

    localparam int unsigned      SEL_W   = clog2_min1(NUM_REDIR);
    localparam int unsigned      LU_W    = clog2_min1(LOAD_USE_STALL + 1);
    localparam int unsigned      TO_W    = clog2_min1(LSU_TIMEOUT + 1);
    localparam logic [LVL_W-1:0] LU_LVL  = LVL_W'(LU_REG);
    localparam logic [LU_W-1:0]  LU_LOAD = LU_W'(LOAD_USE_STALL - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(LSU_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(LSU_TIMEOUT - 1);

    lsu_state_e            state, state_nx;
    logic [LU_W-1:0]       lu_cnt, lu_nx;
    logic [TO_W-1:0]       to_cnt, to_nx;
    logic                  lsu_stall, lu_stall;
    logic                  win_any, ack_ok, cancel;
    logic                  stall_c, timeout_c;
    logic [SEL_W-1:0]      win_sel;
    logic [NUM_REDIR-1:0]  win_onehot, ack_c;
    logic [LVL_W-1:0]      win_lvl;
    logic [NUM_STAGES-1:0] en_c, flush_c;

    hazard_redir_arb #(
        .NUM_REDIR (NUM_REDIR),
        .LVL_W     (LVL_W),
        .SEL_W     (SEL_W)
    ) u_arb (
        .valid   (hz.i_redir_valid),
        .lvl     (hz.i_redir_lvl),
        .any     (win_any),
        .sel     (win_sel),
        .onehot  (win_onehot),
        .win_lvl (win_lvl)
    );

    assign lsu_stall = hz.i_lsu_valid & ~hz.i_lsu_ready;
    assign lu_stall  = hz.i_load_use | (lu_cnt != '0);
    // A redirect deep enough to squash the load consumer may override the load-use stall.
    assign ack_ok    = win_any & ~lsu_stall & (~lu_stall | (win_lvl >= LU_LVL));
    assign cancel    = ack_ok & (win_lvl >= LU_LVL);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= L_IDLE;
            lu_cnt <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_nx;
            lu_cnt <= lu_nx;
            to_cnt <= to_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        lu_nx     = lu_cnt;
        to_nx     = to_cnt;
        timeout_c = 1'b0;

        case (state)
            L_IDLE:  if (lsu_stall) state_nx = L_WAIT;
            L_WAIT:  if (hz.i_lsu_ready || !hz.i_lsu_valid) state_nx = L_IDLE;
            default: state_nx = L_IDLE;
        endcase

        if (state == L_IDLE) begin
            to_nx = '0;
        end else if (to_cnt != TO_MAX) begin
            to_nx = to_cnt + 1'b1;
        end
        timeout_c = (LSU_TIMEOUT != 0) && (state == L_WAIT) && lsu_stall && (to_cnt == TO_LAST);

        if (cancel) begin
            lu_nx = '0;
        end else if (!lsu_stall) begin
            if (hz.i_load_use) begin
                lu_nx = LU_LOAD;
            end else if (lu_cnt != '0) begin
                lu_nx = lu_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        en_c    = '1;
        flush_c = '0;
        ack_c   = '0;
        stall_c = lsu_stall | (lu_stall & ~cancel);

        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (lsu_stall) begin
                if (k <= MEM_REG)     en_c[k]    = 1'b0;
                if (k == MEM_REG + 1) flush_c[k] = 1'b1;
            end else if (lu_stall && !cancel) begin
                if (k < LU_REG)  en_c[k]    = 1'b0;
                if (k == LU_REG) flush_c[k] = 1'b1;
            end
            if (ack_ok && (k != 0) && (k <= 32'(win_lvl))) flush_c[k] = 1'b1;
        end

        if (ack_ok) ack_c = win_onehot;
        // A slot being cleared to a bubble must also be written.
        en_c = en_c | flush_c;

        if (i_rst) begin
            en_c       = '0;
            flush_c    = '1;
            flush_c[0] = 1'b0;
            ack_c      = '0;
            stall_c    = 1'b0;
        end
    end

    assign hz.o_en          = en_c;
    assign hz.o_flush       = flush_c;
    assign hz.o_redir_ack   = ack_c;
    assign hz.o_redir_sel   = win_sel;
    assign hz.o_stall       = stall_c;
    assign hz.o_lsu_timeout = timeout_c & ~i_rst;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (stall_c && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
            if ((ack_c != '0) && (perf_flush != '1)) perf_flush <= perf_flush + 32'd1;
        end
    end

    assign hz.o_perf_stall_cnt = perf_stall;
    assign hz.o_perf_flush_cnt = perf_flush;
`else
    assign hz.o_perf_stall_cnt = '0;
    assign hz.o_perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with a per-cycle rule model and hand-computed vectors.
module tb_pipe_hazard_unit;
    import singlecycle_pkg::*;

    localparam int NS  = 5;
    localparam int NR  = 4;
    localparam int MEM = 3;
    localparam int LUR = 2;
    localparam int LUS = 2;
    localparam int TO  = 2;
    localparam int LW  = 3;
    localparam int SW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.NUM_STAGES(NS), .NUM_REDIR(NR), .LVL_W(LW), .SEL_W(SW)) hz ();

    pipe_hazard_unit #(
        .NUM_STAGES     (NS),
        .NUM_REDIR      (NR),
        .MEM_REG        (MEM),
        .LU_REG         (LUR),
        .LOAD_USE_STALL (LUS),
        .LSU_TIMEOUT    (TO),
        .LVL_W          (LW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Rule model: remaining load-use cycles, length of the current LSU stall run, perf totals.
    int lu_left = 0;
    int run     = 0;
    int m_stall = 0;
    int m_flush = 0;

    always @(negedge clk) begin : model
        int e_en, e_fl, e_ack, e_to, e_st, best, lv;
        bit lsu, lu, ack_ok, cancel;
        lsu = 0; lu = 0; ack_ok = 0; cancel = 0; best = -1; lv = 0;
        if (rst) begin
            e_en = 0; e_fl = 'h1E; e_ack = 0; e_to = 0; e_st = 0;
        end else begin
            lsu = hz.i_lsu_valid && !hz.i_lsu_ready;
            lu  = hz.i_load_use || (lu_left > 0);
            for (int i = 0; i < NR; i++)
                if (hz.i_redir_valid[i] && (best < 0 || int'(hz.i_redir_lvl[i]) > lv)) begin
                    best = i;
                    lv   = int'(hz.i_redir_lvl[i]);
                end
            ack_ok = (best >= 0) && !lsu && (!lu || lv >= LUR);
            cancel = ack_ok && lv >= LUR;
            e_en = (1 << NS) - 1;
            e_fl = 0;
            e_ack = 0;
            if (lsu) begin
                e_en &= ~((1 << (MEM + 1)) - 1);
                if (MEM + 1 < NS) e_fl |= 1 << (MEM + 1);
            end else if (lu && !cancel) begin
                e_en &= ~((1 << LUR) - 1);
                e_fl |= 1 << LUR;
            end
            if (ack_ok) begin
                e_fl |= ((1 << (lv + 1)) - 1) & ~1;
                e_ack = 1 << best;
            end
            e_fl &= (1 << NS) - 1;
            e_en |= e_fl;
            e_to = (TO > 0 && lsu && run == TO) ? 1 : 0;
            e_st = (lsu || (lu && !cancel)) ? 1 : 0;
        end
        check("model.en", 64'(hz.o_en), 64'(e_en));
        check("model.flush", 64'(hz.o_flush), 64'(e_fl));
        check("model.ack", 64'(hz.o_redir_ack), 64'(e_ack));
        check("model.timeout", 64'(hz.o_lsu_timeout), 64'(e_to));
        check("model.stall", 64'(hz.o_stall), 64'(e_st));
        if (ack_ok) check("model.sel", 64'(hz.o_redir_sel), 64'(best));
`ifdef HAZARD_PERF_EN
        if (!rst) begin
            check("model.perf_stall", 64'(hz.o_perf_stall_cnt), 64'(m_stall));
            check("model.perf_flush", 64'(hz.o_perf_flush_cnt), 64'(m_flush));
        end
`else
        check("model.perf_stall", 64'(hz.o_perf_stall_cnt), 64'd0);
        check("model.perf_flush", 64'(hz.o_perf_flush_cnt), 64'd0);
`endif
        if (rst) begin
            lu_left = 0; run = 0; m_stall = 0; m_flush = 0;
        end else begin
            run = lsu ? run + 1 : 0;
            if (cancel) lu_left = 0;
            else if (!lsu) begin
                if (hz.i_load_use) lu_left = LUS - 1;
                else if (lu_left > 0) lu_left--;
            end
            if (e_st != 0) m_stall++;
            if (ack_ok) m_flush++;
        end
    end

    // One cycle of hand-computed expectations; sel/tmo < 0 means "not checked".
    task automatic lit(input string nm, input logic [4:0] en, input logic [4:0] fl,
                       input logic [3:0] ack, input logic st, input int sel, input int tmo);
        @(negedge clk);
        check({nm, ".en"}, 64'(hz.o_en), 64'(en));
        check({nm, ".flush"}, 64'(hz.o_flush), 64'(fl));
        check({nm, ".ack"}, 64'(hz.o_redir_ack), 64'(ack));
        check({nm, ".stall"}, 64'(hz.o_stall), 64'(st));
        if (sel >= 0) check({nm, ".sel"}, 64'(hz.o_redir_sel), 64'(sel));
        if (tmo >= 0) check({nm, ".timeout"}, 64'(hz.o_lsu_timeout), 64'(tmo));
        @(posedge clk);
        #1;
    endtask

    task automatic set_redir(input logic [3:0] v, input int l0, input int l1, input int l2, input int l3);
        hz.i_redir_valid  = v;
        hz.i_redir_lvl[0] = LW'(l0);
        hz.i_redir_lvl[1] = LW'(l1);
        hz.i_redir_lvl[2] = LW'(l2);
        hz.i_redir_lvl[3] = LW'(l3);
    endtask

    initial begin
        set_redir(4'b0000, 0, 0, 0, 0);
        hz.i_load_use  = 1'b0;
        hz.i_lsu_valid = 1'b0;
        hz.i_lsu_ready = 1'b0;

        lit("reset0", 5'b00000, 5'b11110, 4'b0000, 1'b0, -1, 0);
        lit("reset1", 5'b00000, 5'b11110, 4'b0000, 1'b0, -1, 0);
        rst = 1'b0;
        lit("post_rst", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, 0);

        set_redir(4'b0101, 1, 0, 2, 0);
        lit("redir_prio", 5'b11111, 5'b00110, 4'b0100, 1'b0, 2, -1);
        set_redir(4'b1010, 0, 3, 0, 3);
        lit("redir_tie", 5'b11111, 5'b01110, 4'b0010, 1'b0, 1, -1);
        set_redir(4'b0000, 0, 0, 0, 0);
        lit("idle", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, -1);

        hz.i_lsu_valid = 1'b1;
        lit("lsu_w1", 5'b10000, 5'b10000, 4'b0000, 1'b1, -1, 0);
        lit("lsu_w2", 5'b10000, 5'b10000, 4'b0000, 1'b1, -1, 0);
        lit("lsu_w3", 5'b10000, 5'b10000, 4'b0000, 1'b1, -1, 1);
        hz.i_lsu_ready = 1'b1;
        lit("lsu_done", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, 0);
        hz.i_lsu_valid = 1'b0;
        hz.i_lsu_ready = 1'b0;

        hz.i_load_use = 1'b1;
        lit("lu_c1", 5'b11100, 5'b00100, 4'b0000, 1'b1, -1, -1);
        hz.i_load_use = 1'b0;
        lit("lu_c2", 5'b11100, 5'b00100, 4'b0000, 1'b1, -1, -1);
        lit("lu_end", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, -1);

        hz.i_load_use = 1'b1;
        lit("lufz_c1", 5'b11100, 5'b00100, 4'b0000, 1'b1, -1, -1);
        hz.i_load_use = 1'b0;
        hz.i_lsu_valid = 1'b1;
        lit("lufz_lsu", 5'b10000, 5'b10000, 4'b0000, 1'b1, -1, 0);
        hz.i_lsu_valid = 1'b0;
        lit("lufz_c2", 5'b11100, 5'b00100, 4'b0000, 1'b1, -1, -1);
        lit("lufz_end", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, -1);

        hz.i_load_use = 1'b1;
        set_redir(4'b0001, 1, 0, 0, 0);
        lit("lu_r1_a", 5'b11100, 5'b00100, 4'b0000, 1'b1, -1, -1);
        hz.i_load_use = 1'b0;
        lit("lu_r1_b", 5'b11100, 5'b00100, 4'b0000, 1'b1, -1, -1);
        lit("lu_r1_ack", 5'b11111, 5'b00010, 4'b0001, 1'b0, 0, -1);
        set_redir(4'b0000, 0, 0, 0, 0);

        hz.i_load_use = 1'b1;
        set_redir(4'b0001, 2, 0, 0, 0);
        lit("lu_r2_ack", 5'b11111, 5'b00110, 4'b0001, 1'b0, 0, -1);
        hz.i_load_use = 1'b0;
        set_redir(4'b0000, 0, 0, 0, 0);
        lit("lu_r2_after", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, -1);

        hz.i_lsu_valid = 1'b1;
        set_redir(4'b1000, 0, 0, 0, 3);
        lit("rl_hold1", 5'b10000, 5'b10000, 4'b0000, 1'b1, -1, 0);
        lit("rl_hold2", 5'b10000, 5'b10000, 4'b0000, 1'b1, -1, 0);
        hz.i_lsu_ready = 1'b1;
        lit("rl_ack", 5'b11111, 5'b01110, 4'b1000, 1'b0, 3, 0);
        set_redir(4'b0000, 0, 0, 0, 0);
        hz.i_lsu_valid = 1'b0;
        hz.i_lsu_ready = 1'b0;
        lit("rl_after", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, -1);

        hz.i_load_use = 1'b1;
        lit("rst_lu_a", 5'b11100, 5'b00100, 4'b0000, 1'b1, -1, -1);
        hz.i_load_use = 1'b0;
        rst = 1'b1;
        lit("rst_lu_in", 5'b00000, 5'b11110, 4'b0000, 1'b0, -1, 0);
        rst = 1'b0;
        lit("rst_lu_out", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, -1);

        hz.i_lsu_valid = 1'b1;
        lit("rst_w_a", 5'b10000, 5'b10000, 4'b0000, 1'b1, -1, 0);
        lit("rst_w_b", 5'b10000, 5'b10000, 4'b0000, 1'b1, -1, 0);
        rst = 1'b1;
        lit("rst_w_in", 5'b00000, 5'b11110, 4'b0000, 1'b0, -1, 0);
        rst = 1'b0;
        hz.i_lsu_valid = 1'b0;
        lit("rst_w_out", 5'b11111, 5'b00000, 4'b0000, 1'b0, -1, 0);
        check("perf_stall_after_rst", 64'(hz.o_perf_stall_cnt), 64'd0);
        check("perf_flush_after_rst", 64'(hz.o_perf_flush_cnt), 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
